// File: rtl/exp4_defs_pkg.sv
// Shared state codes, debug width default and Moore output decode for the exp4 game.
// The optional TIMEOUT_EN macro enables the timeout ending (fim_timeout / timeout_out).
package exp4_defs;

   localparam int DB_ESTADO_W_PADRAO = 4;

   localparam logic [3:0] COD_INICIAL       = 4'h0;
   localparam logic [3:0] COD_PREPARACAO    = 4'h1;
   localparam logic [3:0] COD_ESPERA_JOGADA = 4'h2;
   localparam logic [3:0] COD_REGISTRA      = 4'h4;
   localparam logic [3:0] COD_COMPARA       = 4'h5;
   localparam logic [3:0] COD_PROXIMO       = 4'h6;
   localparam logic [3:0] COD_FIM_ACERTO    = 4'hA;
   localparam logic [3:0] COD_FIM_ERRO      = 4'hE;
   localparam logic [3:0] COD_FIM_TIMEOUT   = 4'hF;

   typedef enum logic [3:0] {
      INICIAL       = COD_INICIAL,
      PREPARACAO    = COD_PREPARACAO,
      ESPERA_JOGADA = COD_ESPERA_JOGADA,
      REGISTRA      = COD_REGISTRA,
      COMPARA       = COD_COMPARA,
      PROXIMO       = COD_PROXIMO,
      FIM_ACERTO    = COD_FIM_ACERTO,
      FIM_ERRO      = COD_FIM_ERRO,
      FIM_TIMEOUT   = COD_FIM_TIMEOUT
   } estado_t;

   typedef struct packed {
      logic zera_c;
      logic conta_c;
      logic zera_r;
      logic registrar_r;
      logic zera_s_timeout;
      logic registra_modo;
      logic pronto;
      logic acertou;
      logic errou;
      logic timeout_out;
   } saidas_t;

   // Pure state decode; anything outside the named states drives nothing.
   function automatic saidas_t decodifica_saidas(input estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARACAO: begin
            s.zera_c         = 1'b1;
            s.zera_r         = 1'b1;
            s.zera_s_timeout = 1'b1;
            s.registra_modo  = 1'b1;
         end
         REGISTRA: begin
            s.registrar_r    = 1'b1;
            s.zera_s_timeout = 1'b1;
         end
         PROXIMO: begin
            s.conta_c        = 1'b1;
            s.zera_s_timeout = 1'b1;
         end
         FIM_ACERTO: begin
            s.pronto  = 1'b1;
            s.acertou = 1'b1;
         end
         FIM_ERRO: begin
            s.pronto = 1'b1;
            s.errou  = 1'b1;
         end
         FIM_TIMEOUT: begin
            s.pronto      = 1'b1;
            s.timeout_out = 1'b1;
         end
         default: ;
      endcase
`ifndef TIMEOUT_EN
      s.timeout_out = 1'b0;
`endif
      return s;
   endfunction

endpackage

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the exp4 memory-sequence game; drives the datapath strobes.
// Build option TIMEOUT_EN: when defined, espera_jogada honours timeout and fim_timeout is reachable.
module exp4_unidade_controle
   import exp4_defs::*;
#(
   parameter int DB_ESTADO_W = DB_ESTADO_W_PADRAO
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   iniciar,
   input  logic                   jogada_feita,
   input  logic                   igual,
   input  logic                   fimC,
   input  logic                   fim_4_jogadas,
   input  logic                   modo_reg,
   input  logic                   timeout,
   output logic                   zeraC,
   output logic                   contaC,
   output logic                   zeraR,
   output logic                   registrarR,
   output logic                   zera_s_timeout,
   output logic                   registra_modo,
   output logic                   pronto,
   output logic                   acertou,
   output logic                   errou,
   output logic                   timeout_out,
   output logic [DB_ESTADO_W-1:0] db_estado
);

   estado_t estado;
   estado_t estado_prox;
   saidas_t saidas;
   logic    timeout_ef;

`ifdef TIMEOUT_EN
   assign timeout_ef = timeout;
`else
   logic unused_timeout;
   assign unused_timeout = timeout;
   assign timeout_ef     = 1'b0;
`endif

   function automatic estado_t proximo_estado(
      input estado_t e,
      input logic    ini,
      input logic    jog,
      input logic    eq,
      input logic    fim16,
      input logic    fim4,
      input logic    modo4,
      input logic    tout
   );
      estado_t p;
      p = INICIAL;
      case (e)
         INICIAL:       p = ini ? PREPARACAO : INICIAL;
         PREPARACAO:    p = ESPERA_JOGADA;
         // a play arriving together with timeout still counts as a play
         ESPERA_JOGADA: begin
            if (jog)       p = REGISTRA;
            else if (tout) p = FIM_TIMEOUT;
            else           p = ESPERA_JOGADA;
         end
         REGISTRA:      p = COMPARA;
         COMPARA: begin
            if (!eq)                       p = FIM_ERRO;
            else if (modo4 ? fim4 : fim16) p = FIM_ACERTO;
            else                           p = PROXIMO;
         end
         PROXIMO:       p = ESPERA_JOGADA;
         FIM_ACERTO:    p = ini ? PREPARACAO : FIM_ACERTO;
         FIM_ERRO:      p = ini ? PREPARACAO : FIM_ERRO;
         FIM_TIMEOUT:   p = ini ? PREPARACAO : FIM_TIMEOUT;
         default:       p = INICIAL;
      endcase
      return p;
   endfunction

   assign estado_prox = proximo_estado(estado, iniciar, jogada_feita, igual,
                                       fimC, fim_4_jogadas, modo_reg, timeout_ef);

   // Outputs are registered from the decode of the next state, so they change
   // on the same edge as the state and remain a pure function of it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= INICIAL;
         saidas <= '0;
      end else begin
         estado <= estado_prox;
         saidas <= decodifica_saidas(estado_prox);
      end
   end

   assign zeraC          = saidas.zera_c;
   assign contaC         = saidas.conta_c;
   assign zeraR          = saidas.zera_r;
   assign registrarR     = saidas.registrar_r;
   assign zera_s_timeout = saidas.zera_s_timeout;
   assign registra_modo  = saidas.registra_modo;
   assign pronto         = saidas.pronto;
   assign acertou        = saidas.acertou;
   assign errou          = saidas.errou;
   assign timeout_out    = saidas.timeout_out;
   assign db_estado      = DB_ESTADO_W'(estado);

   a_strobes_exclusivos: assert property (
      @(posedge clock) disable iff (reset)
      $onehot0({contaC, registrarR, registra_modo})
   );

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Randomized game-level bench for exp4_unidade_controle: builds expected per-cycle state traces from game rules.
module tb_exp4_unidade_controle;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       jogada_feita = 1'b0;
   logic       igual = 1'b0;
   logic       fimC = 1'b0;
   logic       fim_4_jogadas = 1'b0;
   logic       modo_reg = 1'b0;
   logic       timeout = 1'b0;
   logic       zeraC, contaC, zeraR, registrarR, zera_s_timeout, registra_modo;
   logic       pronto, acertou, errou, timeout_out;
   logic [3:0] db_estado;
   logic [9:0] outs;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       ini, jf, ig, fc, f4, to;
      logic [3:0] exp;
   } ciclo_t;

   ciclo_t     sched_q[$];
   logic [3:0] model_code;

   exp4_unidade_controle #(.DB_ESTADO_W(4)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
      .igual(igual), .fimC(fimC), .fim_4_jogadas(fim_4_jogadas), .modo_reg(modo_reg),
      .timeout(timeout), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
      .registrarR(registrarR), .zera_s_timeout(zera_s_timeout),
      .registra_modo(registra_modo), .pronto(pronto), .acertou(acertou),
      .errou(errou), .timeout_out(timeout_out), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   assign outs = {zeraC, contaC, zeraR, registrarR, zera_s_timeout, registra_modo,
                  pronto, acertou, errou, timeout_out};

   // {zeraC, contaC, zeraR, registrarR, zera_s_timeout, registra_modo, pronto, acertou, errou, timeout_out}
   function automatic logic [9:0] exp_outs(input logic [3:0] c);
      case (c)
         4'h1:    return 10'b1010110000;
         4'h4:    return 10'b0001100000;
         4'h6:    return 10'b0100100000;
         4'hA:    return 10'b0000001100;
         4'hE:    return 10'b0000001010;
         4'hF:    return 10'b0000001001;
         default: return 10'b0000000000;
      endcase
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic ini, input logic jf, input logic ig, input logic fc,
                       input logic f4, input logic to, input logic [3:0] e);
      ciclo_t c;
      c.ini = ini; c.jf = jf; c.ig = ig; c.fc = fc; c.f4 = f4; c.to = to; c.exp = e;
      sched_q.push_back(c);
      model_code = e;
   endtask

   task automatic run_sched(input string name, output int conta_seen);
      ciclo_t c;
      conta_seen = 0;
      while (sched_q.size() > 0) begin
         c = sched_q.pop_front();
         iniciar = c.ini; jogada_feita = c.jf; igual = c.ig;
         fimC = c.fc; fim_4_jogadas = c.f4; timeout = c.to;
         @(posedge clock);
         #1;
         checks++;
         if (db_estado !== c.exp) begin
            errors++;
            $display("FAIL %s state: got %h expected %h at %0t", name, db_estado, c.exp, $time);
         end
         checks++;
         if (outs !== exp_outs(c.exp)) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b (state %h) at %0t",
                     name, outs, exp_outs(c.exp), c.exp, $time);
         end
         if (contaC === 1'b1) conta_seen++;
      end
   endtask

   task automatic add_stays(input int n);
      for (int k = 0; k < n; k++) push(1'b0, rnd(), rnd(), rnd(), rnd(), rnd(), model_code);
   endtask

   // One game from inicial or a final state; err_at/to_at = play index or -1.
   task automatic build_game(input logic modo, input int err_at, input int to_at,
                             output int exp_conta);
      int  n;
      int  waits;
      logic fc, f4;
      n = modo ? 4 : 16;
      exp_conta = 0;
      push(1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), 4'h1);
      push(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 4'h2);
      for (int i = 0; i < n; i++) begin
         fc = (i == 15);
         f4 = (i == 3);
         waits = $urandom_range(0, 3);
         for (int w = 0; w < waits; w++) push(rnd(), 1'b0, rnd(), fc, f4, 1'b0, 4'h2);
         if (i == to_at) begin
`ifdef TIMEOUT_EN
            push(rnd(), 1'b0, rnd(), fc, f4, 1'b1, 4'hF);
            return;
`else
            push(rnd(), 1'b0, rnd(), fc, f4, 1'b1, 4'h2);
`endif
         end
         push(rnd(), 1'b1, rnd(), fc, f4, rnd(), 4'h4);
         push(rnd(), rnd(), rnd(), fc, f4, rnd(), 4'h5);
         if (i == err_at) begin
            push(rnd(), rnd(), 1'b0, fc, f4, rnd(), 4'hE);
            return;
         end
         if (i == n - 1) begin
            push(rnd(), rnd(), 1'b1, fc, f4, rnd(), 4'hA);
            return;
         end
         push(rnd(), rnd(), 1'b1, fc, f4, rnd(), 4'h6);
         exp_conta++;
         push(rnd(), rnd(), rnd(), (i + 1 == 15), (i + 1 == 3), rnd(), 4'h2);
      end
   endtask

   task automatic test_reset();
      int seen;
      reset = 1'b1;
      iniciar = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (db_estado !== 4'h0) begin
         errors++; $display("FAIL reset_state: got %h expected 0", db_estado);
      end
      checks++;
      if (outs !== 10'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 0", outs);
      end
      iniciar = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (db_estado !== 4'h0 || outs !== 10'b0) begin
         errors++; $display("FAIL reset_hold_iniciar: state %h outs %b expected 0/0", db_estado, outs);
      end
      iniciar = 1'b0;
      reset = 1'b0;
      model_code = 4'h0;
      add_stays(3);
      run_sched("reset_idle", seen);
   endtask

   task automatic test_win_4();
      int exp_c, seen;
      modo_reg = 1'b1;
      build_game(1'b1, -1, -1, exp_c);
      add_stays(3);
      run_sched("win_4", seen);
      checks++;
      if (seen !== 3 || exp_c !== 3) begin
         errors++; $display("FAIL win_4 contaC pulses: got %0d expected 3", seen);
      end
   endtask

   task automatic test_error_16();
      int exp_c, seen;
      modo_reg = 1'b0;
      build_game(1'b0, 1, -1, exp_c);
      add_stays(2);
      run_sched("error_16", seen);
      checks++;
      if (seen !== 1) begin
         errors++; $display("FAIL error_16 contaC pulses: got %0d expected 1", seen);
      end
   endtask

   task automatic test_timeout();
      int exp_c, seen;
      modo_reg = 1'b0;
      build_game(1'b0, -1, 2, exp_c);
      add_stays(3);
      run_sched("timeout", seen);
      checks++;
      if (seen !== exp_c) begin
         errors++; $display("FAIL timeout contaC pulses: got %0d expected %0d", seen, exp_c);
      end
   endtask

   task automatic test_jogada_and_timeout();
      int seen;
      modo_reg = 1'b1;
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE);
      run_sched("jogada_and_timeout", seen);
   endtask

   task automatic test_restart_held();
      int exp_c, seen;
      modo_reg = 1'b1;
      build_game(1'b1, -1, -1, exp_c);
      push(1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), 4'h1);
      push(1'b1, 1'b0, rnd(), 1'b0, 1'b0, 1'b0, 4'h2);
      push(1'b1, 1'b0, rnd(), 1'b0, 1'b0, 1'b0, 4'h2);
      push(1'b1, 1'b1, rnd(), 1'b0, 1'b0, 1'b0, 4'h4);
      push(1'b1, 1'b0, rnd(), 1'b0, 1'b0, 1'b0, 4'h5);
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE);
      push(1'b1, 1'b0, rnd(), 1'b0, 1'b0, 1'b0, 4'h1);
      push(1'b0, 1'b0, rnd(), 1'b0, 1'b0, 1'b0, 4'h2);
      push(1'b0, 1'b1, rnd(), 1'b0, 1'b0, 1'b0, 4'h4);
      push(1'b0, 1'b0, rnd(), 1'b0, 1'b0, 1'b0, 4'h5);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE);
      run_sched("restart_held", seen);
   endtask

   task automatic test_reset_mid_game();
      int seen;
      modo_reg = 1'b0;
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4);
      push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
      run_sched("reset_mid_pre", seen);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (db_estado !== 4'h0 || outs !== 10'b0) begin
         errors++;
         $display("FAIL reset_mid_game async: state %h outs %b expected 0/0", db_estado, outs);
      end
      @(negedge clock);
      reset = 1'b0;
      model_code = 4'h0;
      add_stays(2);
      run_sched("reset_mid_post", seen);
   endtask

   task automatic test_random_games();
      int exp_c, seen, n, err_at, to_at;
      logic modo;
      for (int g = 0; g < 8; g++) begin
         modo = rnd();
         n = modo ? 4 : 16;
         err_at = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, n - 1);
         to_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
         modo_reg = modo;
         build_game(modo, err_at, to_at, exp_c);
         add_stays($urandom_range(0, 3));
         run_sched("random_game", seen);
         checks++;
         if (seen !== exp_c) begin
            errors++;
            $display("FAIL random_game %0d contaC pulses: got %0d expected %0d", g, seen, exp_c);
         end
      end
   endtask

   initial begin
      test_reset();
      test_win_4();
      test_error_16();
      test_timeout();
      test_jogada_and_timeout();
      test_restart_held();
      test_reset_mid_game();
      test_random_games();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exp4_unidade_controle.md
Name: exp4_unidade_controle

Overview:
Moore control unit for the exp4 memory-sequence game, directly upstream of the exp4 datapath. Drives the datapath's clear, count, register, timeout-clear and mode-capture strobes. Consumes the datapath's status flags: igual, fimC, jogada_feita, timeout, fim_4_jogadas and db_modo. Reports game result (acertou/errou/timeout) and exposes its state code for debug displays.

Parameters:
DB_ESTADO_W, 4, width of db_estado; must be >= 4, upper bits zero-padded.

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces state inicial
iniciar  input  1  start request, level-sampled
jogada_feita  input  1  1-clock pulse from datapath edge detector
igual  input  1  ROM data equals registered play
fimC  input  1  address counter at 15 (16-play mode end)
fim_4_jogadas  input  1  address counter at 3 (4-play mode end)
modo_reg  input  1  registered mode from datapath (1 = 4 plays, 0 = 16 plays)
timeout  input  1  timeout counter terminal flag
zeraC  output  1  clear address counter
contaC  output  1  increment address counter
zeraR  output  1  clear play register
registrarR  output  1  load play register
zera_s_timeout  output  1  synchronous clear of timeout counter
registra_modo  output  1  capture mode switch
pronto  output  1  game finished
acertou  output  1  finished with full correct sequence
errou  output  1  finished on mismatch
timeout_out  output  1  finished by timeout
db_estado  output  DB_ESTADO_W  current state code

Behaviour:
- State register updates on posedge clock. Async reset clears to inicial. All outputs are decoded from state only (pure Moore), so they are valid in the same cycle as the state.
- While reset is asserted and in inicial, every output is 0 and db_estado = 0.
- Reset mid-game aborts immediately to inicial. Datapath registers are not cleared by this block until the next preparacao.
- States, codes, asserted outputs and transitions:
  - inicial (0x0): none asserted. iniciar=1 -> preparacao, else stay.
  - preparacao (0x1): zeraC, zeraR, zera_s_timeout, registra_modo. -> espera_jogada unconditionally.
  - espera_jogada (0x2): none asserted. jogada_feita=1 -> registra. Else timeout=1 -> fim_timeout. Else stay. If both are 1 in the same cycle, jogada_feita wins.
  - registra (0x4): registrarR, zera_s_timeout. -> compara.
  - compara (0x5): none asserted. Transitions:
    - igual=0 -> fim_erro.
    - Else, if the last play is reached -> fim_acerto. Last play is (modo_reg ? fim_4_jogadas : fimC).
    - Else -> proximo.
  - proximo (0x6): contaC, zera_s_timeout. -> espera_jogada.
  - fim_acerto (0xA): pronto, acertou. iniciar=1 -> preparacao.
  - fim_erro (0xE): pronto, errou. iniciar=1 -> preparacao.
  - fim_timeout (0xF): pronto, timeout_out. iniciar=1 -> preparacao.
  - Any unused code -> inicial on next clock. All outputs are 0 in an unused code.
- Latency: jogada_feita pulse to compara decision is 2 clocks (registra, then compara).
- Synchronous-ROM settling: proximo -> espera_jogada gives at least 1 clock before the next registra. The ROM output is therefore valid when compara samples igual.
- Holding iniciar high at a final state restarts the game on the next clock. A held iniciar never skips preparacao.
- timeout is ignored in every state except espera_jogada.
- At most one of contaC, registrarR and registra_modo is high in any cycle.

Optional Feature:
Macro TIMEOUT_EN.
- Defined: behaviour as above (espera_jogada honours timeout; fim_timeout reachable).
- Undefined: timeout input is ignored, fim_timeout is unreachable, timeout_out is tied to 0, and zera_s_timeout is still driven as specified.

Decomposition:
- Shared package/include exp4_defs holds the state code localparams and the DB_ESTADO default, so the datapath, 7-segment debug decode and testbench share the same codes.
- No sub-module. The block is a single next-state always block, a state register and an output decoder.

Test Plan:
- Reset with iniciar=0 -> state inicial, db_estado=0x0, all strobes 0. Reset asserted in compara -> inicial within the same cycle (async).
- modo_reg=1, iniciar pulse, 4 correct plays (igual=1, fim_4_jogadas=1 on the 4th) -> sequence 1,2,4,5,6 ×3, then 2,4,5,A. pronto=acertou=1. contaC pulsed exactly 3 times.
- modo_reg=0, 2nd play igual=0 -> compara -> fim_erro (0xE), errou=1, acertou=0, contaC pulsed once.
- In espera_jogada, timeout=1 with no jogada_feita -> fim_timeout (0xF), timeout_out=1 (TIMEOUT_EN defined). With the macro undefined, the state stays at 0x2.
- jogada_feita and timeout both 1 in espera_jogada -> registra (0x4), no timeout reported.
- At fim_acerto, iniciar=1 -> preparacao: zeraC, zeraR, zera_s_timeout and registra_modo all high for exactly 1 clock, then espera_jogada.
